muldiv_ctrl: RTL and testbench

Sequencer for the CPU's shared HI/LO resource. It accepts a multiply or divide request from the main control unit, launches the selected iterative unit (multiplier or divider), and waits for that unit's completion. It then commits the result into HI and LO by driving their write enables and source selects, and reports completion, a divide-by-zero exception, or a watchdog timeout back to the control unit. It removes per-cycle mult/div bookkeeping from the main FSM: the control unit only pulses `start` and waits on `done`/`div_zero`.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_ctrl.sv | 158 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  // Sequencer states; IDLE is encoded as zero so a cleared register means idle.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_EXC    = 3'd5
  } muldiv_state_t;

  // Operation select carried on `op`.
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // HI/LO input mux select values.
  localparam logic HILO_SRC_MULT = 1'b0;
  localparam logic HILO_SRC_DIV  = 1'b1;

  // Watchdog counter width; TIMEOUT_CYCLES is limited to 255 so it never wraps.
  localparam int CNT_W = 8;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared HI/LO resource: launches the multiplier or divider,
// waits for its completion under a watchdog, then commits into HI/LO.
//
// Control-unit handshake: `start` is a request strobe that is only sampled in
// IDLE or DONE (it is dropped, not queued, in every other state). Each accepted
// request is answered by exactly one of: a one-cycle `done` pulse (with
// `timeout` qualifying it when the watchdog fired), or a one-cycle `div_zero`
// pulse. Unit handshake: a one-cycle `*_start` pulse launches the unit; only
// the selected unit's `*_done` is looked at, and only while waiting.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [31:0]   divisor,
  input  logic          mult_done,
  input  logic          div_done,
  output logic          mult_start,
  output logic          div_start,
  output logic          hi_w,
  output logic          lo_w,
  output logic          hilo_src,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          div_zero,
  output muldiv_state_t dbg_state
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  muldiv_state_t    r_state;
  muldiv_state_t    w_next;
  logic             r_op_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  logic w_div_by_zero;
  logic w_sel_done;
  logic w_cnt_last;

  // A divide request with a zero divisor is trapped before any unit is started.
  assign w_div_by_zero = (op == OP_DIV) && (divisor == 32'd0);
  // Only the launched unit's completion matters; the other one is ignored.
  assign w_sel_done    = (r_op_q == OP_DIV) ? div_done : mult_done;
  assign w_cnt_last    = (r_cnt == LP_CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = w_div_by_zero ? S_EXC : S_LAUNCH;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_sel_done) begin
          w_next = S_WRITE;
        end else if (w_cnt_last) begin
          w_next = S_DONE;
        end
      end
      S_WRITE: w_next = S_DONE;
      S_EXC:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operation latch, watchdog counter and timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_q    <= OP_MULT;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE lasts one cycle, so the flag is gone once it is left.
          r_timeout <= 1'b0;
          if (start && !w_div_by_zero) begin
            r_op_q <= op;
          end
        end
        S_LAUNCH: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (!w_sel_done) begin
            if (w_cnt_last) begin
              r_timeout <= 1'b1;
            end else begin
              r_cnt <= r_cnt + LP_CNT_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore output decode from state and registers only.
  always_comb begin
    mult_start = 1'b0;
    div_start  = 1'b0;
    hi_w       = 1'b0;
    lo_w       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    div_zero   = 1'b0;
    hilo_src   = (r_op_q == OP_DIV) ? HILO_SRC_DIV : HILO_SRC_MULT;
    dbg_state  = r_state;
    case (r_state)
      S_LAUNCH: begin
        busy       = 1'b1;
        mult_start = (r_op_q == OP_MULT);
        div_start  = (r_op_q == OP_DIV);
      end
      S_WAIT: begin
        busy = 1'b1;
      end
      S_WRITE: begin
        busy = 1'b1;
        hi_w = 1'b1;
        lo_w = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        timeout = r_timeout;
      end
      S_EXC: begin
        div_zero = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a default-timeout instance and a
// TIMEOUT_CYCLES=4 instance share the same stimulus; each scenario pushes the
// per-cycle expected output word into exp_q and the cycle loop pops/compares.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W    = 12;
  localparam int NCYC = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] divisor;
  logic        mult_done;
  logic        div_done;

  logic mult_start_a, div_start_a, hi_w_a, lo_w_a, hilo_src_a, busy_a, done_a, timeout_a, div_zero_a;
  logic mult_start_b, div_start_b, hi_w_b, lo_w_b, hilo_src_b, busy_b, done_b, timeout_b, div_zero_b;
  muldiv_state_t dbg_state_a, dbg_state_b;

  logic [W-1:0] obs_a, obs_b;
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle stimulus tables, index = cycle number (start sampled at end of cycle 0).
  bit          c_start[NCYC];
  bit          c_op[NCYC];
  bit          c_md[NCYC];
  bit          c_dd[NCYC];
  bit          c_rst[NCYC];
  logic [31:0] c_div[NCYC];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  muldiv_ctrl u_dut_a (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor(divisor),
    .mult_done(mult_done), .div_done(div_done),
    .mult_start(mult_start_a), .div_start(div_start_a), .hi_w(hi_w_a), .lo_w(lo_w_a),
    .hilo_src(hilo_src_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .div_zero(div_zero_a), .dbg_state(dbg_state_a)
  );

  muldiv_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .op(op), .divisor(divisor),
    .mult_done(mult_done), .div_done(div_done),
    .mult_start(mult_start_b), .div_start(div_start_b), .hi_w(hi_w_b), .lo_w(lo_w_b),
    .hilo_src(hilo_src_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .div_zero(div_zero_b), .dbg_state(dbg_state_b)
  );

  assign obs_a = {dbg_state_a, mult_start_a, div_start_a, hi_w_a, lo_w_a, hilo_src_a,
                  busy_a, done_a, timeout_a, div_zero_a};
  assign obs_b = {dbg_state_b, mult_start_b, div_start_b, hi_w_b, lo_w_b, hilo_src_b,
                  busy_b, done_b, timeout_b, div_zero_b};

  // ---------------- expected-word helpers ----------------
  function automatic logic [W-1:0] mk(muldiv_state_t st, bit ms, bit ds, bit hw, bit src,
                                      bit bsy, bit dn, bit to, bit dz);
    return {st, ms, ds, hw, hw, src, bsy, dn, to, dz};
  endfunction

  // Normal operation launched in cycle c0 whose unit raises done in cycle k.
  function automatic logic [W-1:0] norm_vec(int c, int c0, int k, bit o);
    if (c == c0)                return mk(S_LAUNCH, !o, o, 1'b0, o, 1'b1, 1'b0, 1'b0, 1'b0);
    else if (c > c0 && c <= k)  return mk(S_WAIT, 1'b0, 1'b0, 1'b0, o, 1'b1, 1'b0, 1'b0, 1'b0);
    else if (c == k + 1)        return mk(S_WRITE, 1'b0, 1'b0, 1'b1, o, 1'b1, 1'b0, 1'b0, 1'b0);
    else if (c == k + 2)        return mk(S_DONE, 1'b0, 1'b0, 1'b0, o, 1'b0, 1'b1, 1'b0, 1'b0);
    else                        return mk(S_IDLE, 1'b0, 1'b0, 1'b0, o, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // MULT launched in cycle 1 whose unit never answers; watchdog of t cycles.
  function automatic logic [W-1:0] to_vec(int c, int t);
    if (c == 1)                  return mk(S_LAUNCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    else if (c >= 2 && c <= t + 1) return mk(S_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    else if (c == t + 2)         return mk(S_DONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    else                         return mk(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (state,ms,ds,hiw,low,src,busy,done,to,dz)",
               tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stim();
    for (int i = 0; i < NCYC; i++) begin
      c_start[i] = 1'b0;
      c_op[i]    = 1'b0;
      c_md[i]    = 1'b0;
      c_dd[i]    = 1'b0;
      c_rst[i]   = 1'b0;
      c_div[i]   = 32'd9;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    op        = 1'b0;
    divisor   = 32'd9;
    mult_done = 1'b0;
    div_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives cycles 0..ncyc from the tables; from cycle 1 pops one expected word per cycle.
  task automatic run(input string tag, input int ncyc, input bit sel_b);
    logic [W-1:0] e;
    for (int c = 0; c <= ncyc; c++) begin
      reset     = c_rst[c];
      start     = c_start[c];
      op        = c_op[c];
      divisor   = c_div[c];
      mult_done = c_md[c];
      div_done  = c_dd[c];
      if (c > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq($sformatf("%s c%0d", tag, c), sel_b ? obs_b : obs_a, e);
      end
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    start     = 1'b0;
    mult_done = 1'b0;
    div_done  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    do_reset();
    @(negedge clk);
    check_eq("reset_a", obs_a, '0);
    check_eq("reset_b", obs_b, '0);
    @(posedge clk);
    #1;

    // MULT, multiplier done 33 cycles after the launch pulse (cycle 34).
    do_reset(); clear_stim();
    c_start[0] = 1'b1; c_op[0] = OP_MULT; c_md[34] = 1'b1;
    for (int c = 1; c <= 38; c++) exp_q.push_back(norm_vec(c, 1, 34, 1'b0));
    run("mult", 38, 1'b0);

    // DIV by 7, divider done in cycle 4, multiplier done held high throughout.
    do_reset(); clear_stim();
    c_start[0] = 1'b1; c_op[0] = OP_DIV; c_dd[4] = 1'b1;
    for (int i = 0; i < NCYC; i++) begin c_div[i] = 32'd7; c_md[i] = 1'b1; end
    for (int c = 1; c <= 7; c++) exp_q.push_back(norm_vec(c, 1, 4, 1'b1));
    run("div7", 7, 1'b0);

    // DIV by zero: exception pulse only, then idle.
    do_reset(); clear_stim();
    c_start[0] = 1'b1; c_op[0] = OP_DIV;
    for (int i = 0; i < NCYC; i++) c_div[i] = 32'd0;
    exp_q.push_back(mk(S_EXC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int c = 2; c <= 4; c++) exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run("divzero", 4, 1'b0);

    // Watchdog with TIMEOUT_CYCLES=4, multiplier never answers.
    do_reset(); clear_stim();
    c_start[0] = 1'b1; c_op[0] = OP_MULT;
    for (int c = 1; c <= 8; c++) exp_q.push_back(to_vec(c, 4));
    run("timeout4", 8, 1'b1);

    // Watchdog with the default of 40 cycles.
    do_reset(); clear_stim();
    c_start[0] = 1'b1; c_op[0] = OP_MULT;
    for (int c = 1; c <= 44; c++) exp_q.push_back(to_vec(c, 40));
    run("timeout40", 44, 1'b0);

    // Back-to-back: start during WAIT is dropped, start in DONE launches a DIV directly.
    do_reset(); clear_stim();
    c_start[0] = 1'b1; c_op[0] = OP_MULT;
    c_start[3] = 1'b1; c_op[3] = OP_MULT;
    c_md[4]    = 1'b1;
    c_start[6] = 1'b1; c_op[6] = OP_DIV; c_div[6] = 32'd5;
    c_dd[9]    = 1'b1;
    for (int c = 1; c <= 6; c++)  exp_q.push_back(norm_vec(c, 1, 4, 1'b0));
    for (int c = 7; c <= 13; c++) exp_q.push_back(norm_vec(c, 7, 9, 1'b1));
    run("b2b", 13, 1'b0);

    // Reset during WAIT abandons the operation; a late unit done writes nothing.
    do_reset(); clear_stim();
    c_start[0] = 1'b1; c_op[0] = OP_MULT;
    c_rst[3]   = 1'b1;
    c_md[6]    = 1'b1;
    for (int c = 1; c <= 3; c++) exp_q.push_back(norm_vec(c, 1, 99, 1'b0));
    for (int c = 4; c <= 10; c++) exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run("rst_wait", 10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
